axi3_burst_initiator: RTL and testbench

Parametrised AXI3 initiator that turns single-request read/write commands into INCR bursts of 1 to 16 beats on a Zynq HP slave port, with real byte strobes and response tracking. It sits between a fabric client (DMA, cartridge/framebuffer fetch) and the PS slave port. It supersedes the fixed single-beat, all-strobes-on tie-off.

---
 rtl/axi3_pkg.sv | 41 ++++
 rtl/axi3_burst_initiator.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_axi3_burst_initiator.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi3_pkg.sv
// Shared AXI3 definitions: response codes, burst types, size helper and the
// initiator state encoding.
package axi3_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } axi_resp_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5
    } axi3_state_e;

    function automatic logic [2:0] size_from_width(input int unsigned data_w);
        case (data_w)
            8:       return 3'd0;
            16:      return 3'd1;
            32:      return 3'd2;
            64:      return 3'd3;
            128:     return 3'd4;
            default: return 3'd3;
        endcase
    endfunction

    // Responses are ordered by severity, so "worst" is the numeric maximum.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi3_burst_initiator.sv
// Single-outstanding AXI3 INCR burst initiator (1..16 beats) for a Zynq HP port.
// Optional AXI3_ERR_COUNT_EN adds a saturating err_count output.
module axi3_burst_initiator
    import axi3_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned ID_W   = 6,
    parameter int unsigned AXI_ID = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [3:0]          req_len,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_last,
    output logic                done,
    output logic [1:0]          done_resp,
    output logic [ADDR_W-1:0]   axi_araddr,
    output logic [3:0]          axi_arlen,
    output logic [2:0]          axi_arsize,
    output logic [1:0]          axi_arburst,
    output logic [ID_W-1:0]     axi_arid,
    output logic [3:0]          axi_arcache,
    output logic [2:0]          axi_arprot,
    output logic [1:0]          axi_arlock,
    output logic [3:0]          axi_arqos,
    output logic                axi_arvalid,
    input  logic                axi_arready,
    input  logic                axi_rvalid,
    output logic                axi_rready,
    input  logic [DATA_W-1:0]   axi_rdata,
    input  logic [1:0]          axi_rresp,
    input  logic                axi_rlast,
    output logic [ADDR_W-1:0]   axi_awaddr,
    output logic [3:0]          axi_awlen,
    output logic [2:0]          axi_awsize,
    output logic [1:0]          axi_awburst,
    output logic [ID_W-1:0]     axi_awid,
    output logic [3:0]          axi_awcache,
    output logic [2:0]          axi_awprot,
    output logic [1:0]          axi_awlock,
    output logic [3:0]          axi_awqos,
    output logic                axi_awvalid,
    input  logic                axi_awready,
    output logic                axi_wvalid,
    input  logic                axi_wready,
    output logic [DATA_W-1:0]   axi_wdata,
    output logic [DATA_W/8-1:0] axi_wstrb,
    output logic                axi_wlast,
    output logic [ID_W-1:0]     axi_wid,
    input  logic                axi_bvalid,
    output logic                axi_bready,
    input  logic [1:0]          axi_bresp
`ifdef AXI3_ERR_COUNT_EN
    ,
    output logic [7:0]          err_count
`endif
);

    localparam logic [2:0]        AXSIZE   = size_from_width(DATA_W);
    localparam logic [ADDR_W-1:0] LSB_MASK = (ADDR_W'(1) << AXSIZE) - ADDR_W'(1);
    localparam logic [ID_W-1:0]   ID_VAL   = ID_W'(AXI_ID);

    axi3_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              arvalid_q, arvalid_d;
    logic              awvalid_q, awvalid_d;
    logic              bready_q, bready_d;
    logic              done_q, done_d;
    logic [1:0]        done_resp_q, done_resp_d;
    logic [1:0]        worst_q, worst_d;
    logic              mism_q, mism_d;
`ifdef AXI3_ERR_COUNT_EN
    logic [7:0]        err_count_q, err_count_d;
`endif

    logic beat_last_s;
    logic r_hs_s;
    logic w_hs_s;

    assign beat_last_s = (cnt_q == len_q);
    assign r_hs_s      = (state_q == ST_R) && axi_rvalid && rd_ready;
    assign w_hs_s      = (state_q == ST_W) && wr_valid && axi_wready;

    // Next-state, beat counting and response accumulation.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        arvalid_d   = arvalid_q;
        awvalid_d   = awvalid_q;
        bready_d    = bready_q;
        done_d      = 1'b0;
        done_resp_d = done_resp_q;
        worst_d     = worst_q;
        mism_d      = mism_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr & ~LSB_MASK;
                    len_d   = req_len;
                    cnt_d   = 4'd0;
                    worst_d = RESP_OKAY;
                    mism_d  = 1'b0;
                    if (req_write) begin
                        awvalid_d = 1'b1;
                        state_d   = ST_AW;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_AR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_AR: begin
                if (axi_arready) begin
                    arvalid_d = 1'b0;
                    cnt_d     = 4'd0;
                    state_d   = ST_R;
                end else begin
                    arvalid_d = 1'b1;
                end
            end
            ST_R: begin
                if (r_hs_s) begin
                    worst_d = resp_max(worst_q, axi_rresp);
                    // rlast is trusted; a disagreement with our own count is only reported.
                    mism_d  = mism_q | (axi_rlast != beat_last_s);
                    if (axi_rlast) begin
                        done_d      = 1'b1;
                        done_resp_d = mism_d ? resp_max(worst_d, RESP_SLVERR) : worst_d;
                        state_d     = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_AW: begin
                if (axi_awready) begin
                    awvalid_d = 1'b0;
                    cnt_d     = 4'd0;
                    state_d   = ST_W;
                end else begin
                    awvalid_d = 1'b1;
                end
            end
            ST_W: begin
                if (w_hs_s) begin
                    if (beat_last_s) begin
                        bready_d = 1'b1;
                        state_d  = ST_B;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_B: begin
                if (axi_bvalid) begin
                    bready_d    = 1'b0;
                    done_d      = 1'b1;
                    done_resp_d = axi_bresp;
                    state_d     = ST_IDLE;
                end else begin
                    bready_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                arvalid_d = 1'b0;
                awvalid_d = 1'b0;
                bready_d  = 1'b0;
            end
        endcase
`ifdef AXI3_ERR_COUNT_EN
        if (done_d && (done_resp_d != RESP_OKAY) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
`endif
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= 4'd0;
            cnt_q       <= 4'd0;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
            done_resp_q <= 2'd0;
            worst_q     <= 2'd0;
            mism_q      <= 1'b0;
`ifdef AXI3_ERR_COUNT_EN
            err_count_q <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            arvalid_q   <= arvalid_d;
            awvalid_q   <= awvalid_d;
            bready_q    <= bready_d;
            done_q      <= done_d;
            done_resp_q <= done_resp_d;
            worst_q     <= worst_d;
            mism_q      <= mism_d;
`ifdef AXI3_ERR_COUNT_EN
            err_count_q <= err_count_d;
`endif
        end
    end

    assign req_ready   = (state_q == ST_IDLE);

    assign axi_araddr  = addr_q;
    assign axi_arlen   = len_q;
    assign axi_arsize  = AXSIZE;
    assign axi_arburst = BURST_INCR;
    assign axi_arid    = ID_VAL;
    assign axi_arcache = 4'd0;
    assign axi_arprot  = 3'd0;
    assign axi_arlock  = 2'd0;
    assign axi_arqos   = 4'd0;
    assign axi_arvalid = arvalid_q;

    assign axi_awaddr  = addr_q;
    assign axi_awlen   = len_q;
    assign axi_awsize  = AXSIZE;
    assign axi_awburst = BURST_INCR;
    assign axi_awid    = ID_VAL;
    assign axi_awcache = 4'd0;
    assign axi_awprot  = 3'd0;
    assign axi_awlock  = 2'd0;
    assign axi_awqos   = 4'd0;
    assign axi_awvalid = awvalid_q;

    // Data channels are pure pass-through so bursts stream at full rate.
    assign rd_valid    = (state_q == ST_R) && axi_rvalid;
    assign axi_rready  = (state_q == ST_R) && rd_ready;
    assign rd_data     = axi_rdata;
    assign rd_last     = axi_rlast;

    assign axi_wvalid  = (state_q == ST_W) && wr_valid;
    assign wr_ready    = (state_q == ST_W) && axi_wready;
    assign axi_wdata   = wr_data;
    assign axi_wstrb   = wr_strb;
    assign axi_wlast   = (state_q == ST_W) && beat_last_s;
    assign axi_wid     = ID_VAL;

    assign axi_bready  = bready_q;
    assign done        = done_q;
    assign done_resp   = done_resp_q;
`ifdef AXI3_ERR_COUNT_EN
    assign err_count   = err_count_q;
`endif

endmodule

// File: tb/tb_axi3_burst_initiator.sv
// Scoreboard bench for axi3_burst_initiator: a 64-bit instance for the burst
// scenarios and a 32-bit instance for narrow size/strobe forwarding.
module tb_axi3_burst_initiator;
    import axi3_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic        wr_valid, wr_ready;
    logic [63:0] wr_data;
    logic [7:0]  wr_strb;
    logic        rd_valid, rd_ready, rd_last, done;
    logic [63:0] rd_data;
    logic [1:0]  done_resp;
    logic [31:0] axi_araddr, axi_awaddr;
    logic [3:0]  axi_arlen, axi_awlen, axi_arcache, axi_awcache, axi_arqos, axi_awqos;
    logic [2:0]  axi_arsize, axi_awsize, axi_arprot, axi_awprot;
    logic [1:0]  axi_arburst, axi_awburst, axi_arlock, axi_awlock, axi_rresp, axi_bresp;
    logic [5:0]  axi_arid, axi_awid, axi_wid;
    logic        axi_arvalid, axi_arready, axi_awvalid, axi_awready;
    logic        axi_rvalid, axi_rready, axi_rlast;
    logic [63:0] axi_rdata, axi_wdata;
    logic        axi_wvalid, axi_wready, axi_wlast, axi_bvalid, axi_bready;
    logic [7:0]  axi_wstrb;
`ifdef AXI3_ERR_COUNT_EN
    logic [7:0]  err_count, err_count_n;
`endif

    logic        req_valid_n, req_ready_n, req_write_n;
    logic [31:0] req_addr_n;
    logic [3:0]  req_len_n;
    logic        wr_valid_n, wr_ready_n;
    logic [31:0] wr_data_n, rd_data_n, axi_rdata_n, axi_wdata_n;
    logic [3:0]  wr_strb_n, axi_wstrb_n;
    logic        rd_valid_n, rd_last_n, done_n;
    logic [1:0]  done_resp_n;
    logic [31:0] axi_araddr_n, axi_awaddr_n;
    logic [3:0]  axi_arlen_n, axi_awlen_n, axi_arcache_n, axi_awcache_n, axi_arqos_n, axi_awqos_n;
    logic [2:0]  axi_arsize_n, axi_awsize_n, axi_arprot_n, axi_awprot_n;
    logic [1:0]  axi_arburst_n, axi_awburst_n, axi_arlock_n, axi_awlock_n, axi_bresp_n;
    logic [5:0]  axi_arid_n, axi_awid_n, axi_wid_n;
    logic        axi_arvalid_n, axi_awvalid_n, axi_awready_n, axi_rready_n;
    logic        axi_wvalid_n, axi_wready_n, axi_wlast_n, axi_bvalid_n, axi_bready_n;

    axi3_burst_initiator #(.DATA_W(64), .ADDR_W(32), .ID_W(6), .AXI_ID(0)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_resp(done_resp),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst), .axi_arid(axi_arid), .axi_arcache(axi_arcache),
        .axi_arprot(axi_arprot), .axi_arlock(axi_arlock), .axi_arqos(axi_arqos),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awid(axi_awid), .axi_awcache(axi_awcache),
        .axi_awprot(axi_awprot), .axi_awlock(axi_awlock), .axi_awqos(axi_awqos),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wid(axi_wid),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp)
`ifdef AXI3_ERR_COUNT_EN
        , .err_count(err_count)
`endif
    );

    axi3_burst_initiator #(.DATA_W(32), .ADDR_W(32), .ID_W(6), .AXI_ID(0)) dut_n (
        .clock(clock), .reset(reset),
        .req_valid(req_valid_n), .req_ready(req_ready_n), .req_write(req_write_n),
        .req_addr(req_addr_n), .req_len(req_len_n),
        .wr_valid(wr_valid_n), .wr_ready(wr_ready_n), .wr_data(wr_data_n), .wr_strb(wr_strb_n),
        .rd_valid(rd_valid_n), .rd_ready(1'b1), .rd_data(rd_data_n), .rd_last(rd_last_n),
        .done(done_n), .done_resp(done_resp_n),
        .axi_araddr(axi_araddr_n), .axi_arlen(axi_arlen_n), .axi_arsize(axi_arsize_n),
        .axi_arburst(axi_arburst_n), .axi_arid(axi_arid_n), .axi_arcache(axi_arcache_n),
        .axi_arprot(axi_arprot_n), .axi_arlock(axi_arlock_n), .axi_arqos(axi_arqos_n),
        .axi_arvalid(axi_arvalid_n), .axi_arready(1'b0),
        .axi_rvalid(1'b0), .axi_rready(axi_rready_n), .axi_rdata(axi_rdata_n),
        .axi_rresp(2'b00), .axi_rlast(1'b0),
        .axi_awaddr(axi_awaddr_n), .axi_awlen(axi_awlen_n), .axi_awsize(axi_awsize_n),
        .axi_awburst(axi_awburst_n), .axi_awid(axi_awid_n), .axi_awcache(axi_awcache_n),
        .axi_awprot(axi_awprot_n), .axi_awlock(axi_awlock_n), .axi_awqos(axi_awqos_n),
        .axi_awvalid(axi_awvalid_n), .axi_awready(axi_awready_n),
        .axi_wvalid(axi_wvalid_n), .axi_wready(axi_wready_n), .axi_wdata(axi_wdata_n),
        .axi_wstrb(axi_wstrb_n), .axi_wlast(axi_wlast_n), .axi_wid(axi_wid_n),
        .axi_bvalid(axi_bvalid_n), .axi_bready(axi_bready_n), .axi_bresp(axi_bresp_n)
`ifdef AXI3_ERR_COUNT_EN
        , .err_count(err_count_n)
`endif
    );

    assign axi_rdata_n = 32'd0;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_err = 0;

    logic [64:0] rd_sb[$];
    logic [71:0] w_sb[$];
    logic [1:0]  done_sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pat(input logic [31:0] a, input int i);
        return {a ^ 32'h5A5A_0000, 32'(i) * 32'h0101_0101};
    endfunction

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len;
        @(negedge clock);
        check("req_ready_idle", req_ready, 1);
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic addr_phase(input logic wr, input logic [31:0] exp_addr, input logic [3:0] len,
                              input int delay);
        for (int c = 0; c < delay; c++) begin
            @(negedge clock);
            check("avalid_hold", wr ? axi_awvalid : axi_arvalid, 1);
            check("aaddr_hold", wr ? axi_awaddr : axi_araddr, exp_addr);
            check("req_ready_busy", req_ready, 0);
            @(posedge clock); #1;
        end
        if (wr) axi_awready = 1'b1; else axi_arready = 1'b1;
        @(negedge clock);
        check("avalid", wr ? axi_awvalid : axi_arvalid, 1);
        check("aaddr", wr ? axi_awaddr : axi_araddr, exp_addr);
        check("alen", wr ? axi_awlen : axi_arlen, len);
        check("asize", wr ? axi_awsize : axi_arsize, 3);
        check("aburst", wr ? axi_awburst : axi_arburst, 1);
        @(posedge clock); #1;
        axi_awready = 1'b0; axi_arready = 1'b0;
    endtask

    task automatic finish_txn();
        logic [1:0] exp_r;
        @(negedge clock);
        check("done_pulse", done, 1);
        check("req_ready_done", req_ready, 1);
        if (done_sb.size() > 0) begin
            exp_r = done_sb.pop_front();
            check("done_resp", done_resp, exp_r);
            if (exp_r != 2'd0 && exp_err < 255) exp_err++;
        end else begin
            check("done_sb_empty", 0, 1);
        end
`ifdef AXI3_ERR_COUNT_EN
        check("err_count", err_count, exp_err);
`endif
        @(posedge clock); #1;
        @(negedge clock);
        check("done_drop", done, 0);
        @(posedge clock); #1;
    endtask

    task automatic read_data(input logic [31:0] addr, input logic [3:0] len,
                             input int err_beat, input logic [1:0] err_resp, input int early);
        logic [1:0] worst = 2'd0;
        logic       mism = 1'b0;
        logic       lst;
        logic [64:0] e;
        for (int i = 0; i <= int'(len); i++) begin
            lst   = (i == int'(len)) || (i == early);
            worst = resp_max(worst, (i == err_beat) ? err_resp : 2'd0);
            if (lst != (i == int'(len))) mism = 1'b1;
            if (lst) break;
        end
        done_sb.push_back(mism ? resp_max(worst, 2'd2) : worst);
        for (int i = 0; i <= int'(len); i++) begin
            lst        = (i == int'(len)) || (i == early);
            axi_rvalid = 1'b1;
            axi_rdata  = pat(addr, i);
            axi_rresp  = (i == err_beat) ? err_resp : 2'd0;
            axi_rlast  = lst;
            rd_sb.push_back({lst, pat(addr, i)});
            for (int w = 0; w < 4; w++) begin
                rd_ready = !(i == 1 && w == 0);
                @(negedge clock);
                check("rd_valid", rd_valid, 1);
                check("axi_rready", axi_rready, rd_ready);
                check("done_idle", done, 0);
                if (rd_ready) begin
                    e = rd_sb.pop_front();
                    check("rd_data", rd_data, e[63:0]);
                    check("rd_last", rd_last, e[64]);
                end
                @(posedge clock); #1;
                if (rd_ready) break;
            end
            if (lst) break;
        end
        axi_rvalid = 1'b0; axi_rlast = 1'b0; rd_ready = 1'b1;
        finish_txn();
    endtask

    task automatic write_data(input logic [31:0] addr, input logic [3:0] len,
                              input logic [31:0] strbs, input logic toggle, input logic [1:0] bresp);
        int beat = 0;
        int pushed = -1;
        int guard = 0;
        logic [71:0] e;
        axi_wready = 1'b0;
        while (beat <= int'(len) && guard < 64) begin
            wr_valid = 1'b1;
            wr_data  = pat(addr, beat);
            wr_strb  = strbs[8*beat +: 8];
            if (pushed != beat) begin
                w_sb.push_back({wr_strb, wr_data});
                pushed = beat;
            end
            axi_wready = toggle ? ~axi_wready : 1'b1;
            @(negedge clock);
            check("axi_wvalid", axi_wvalid, 1);
            check("wr_ready", wr_ready, axi_wready);
            check("wlast", axi_wlast, beat == int'(len));
            check("done_idle", done, 0);
            if (axi_wready) begin
                e = w_sb.pop_front();
                check("wdata", axi_wdata, e[63:0]);
                check("wstrb", axi_wstrb, e[71:64]);
                beat++;
            end
            @(posedge clock); #1;
            guard++;
        end
        if (guard >= 64) check("w_timeout", 0, 1);
        wr_valid = 1'b0; axi_wready = 1'b0;
        @(negedge clock);
        check("bready", axi_bready, 1);
        check("axi_wvalid_off", axi_wvalid, 0);
        @(posedge clock); #1;
        axi_bvalid = 1'b1; axi_bresp = bresp;
        done_sb.push_back(bresp);
        @(negedge clock);
        check("done_before_b", done, 0);
        @(posedge clock); #1;
        axi_bvalid = 1'b0;
        finish_txn();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        req_valid = 0; req_write = 0; req_addr = 0; req_len = 0;
        wr_valid = 1; wr_data = 0; wr_strb = 0; rd_ready = 1;
        axi_arready = 0; axi_awready = 0; axi_rvalid = 1; axi_rdata = 0; axi_rresp = 0;
        axi_rlast = 0; axi_wready = 1; axi_bvalid = 0; axi_bresp = 0;
        req_valid_n = 0; req_write_n = 0; req_addr_n = 0; req_len_n = 0;
        wr_valid_n = 0; wr_data_n = 0; wr_strb_n = 0;
        axi_awready_n = 0; axi_wready_n = 0; axi_bvalid_n = 0; axi_bresp_n = 0;

        @(negedge clock);
        check("rst_req_ready", req_ready, 1);
        check("rst_arvalid", axi_arvalid, 0);
        check("rst_awvalid", axi_awvalid, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rready", axi_rready, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_wvalid", axi_wvalid, 0);
        check("rst_bready", axi_bready, 0);
        check("rst_done", done, 0);
        check("rst_done_resp", done_resp, 0);
        @(posedge clock); #1;
        reset = 0; wr_valid = 0; axi_rvalid = 0; axi_wready = 0;

        send_cmd(1'b0, 32'h1000_0007, 4'd0);
        addr_phase(1'b0, 32'h1000_0000, 4'd0, 0);
        read_data(32'h1000_0000, 4'd0, -1, 2'd0, -1);

        send_cmd(1'b1, 32'h2000_0100, 4'd3);
        addr_phase(1'b1, 32'h2000_0100, 4'd3, 1);
        write_data(32'h2000_0100, 4'd3, 32'h01F0_0FFF, 1'b1, 2'd0);

        send_cmd(1'b0, 32'h2000_0045, 4'd2);
        addr_phase(1'b0, 32'h2000_0040, 4'd2, 5);
        read_data(32'h2000_0040, 4'd2, -1, 2'd0, -1);

        send_cmd(1'b0, 32'h3000_0000, 4'd15);
        addr_phase(1'b0, 32'h3000_0000, 4'd15, 0);
        read_data(32'h3000_0000, 4'd15, 7, 2'd2, -1);

        send_cmd(1'b0, 32'h3000_1000, 4'd1);
        addr_phase(1'b0, 32'h3000_1000, 4'd1, 0);
        read_data(32'h3000_1000, 4'd1, -1, 2'd0, 0);

        send_cmd(1'b1, 32'h4000_0008, 4'd0);
        addr_phase(1'b1, 32'h4000_0008, 4'd0, 0);
        write_data(32'h4000_0008, 4'd0, 32'h0000_00AA, 1'b0, 2'd3);

        // Reset while the third of four write beats is on the bus.
        send_cmd(1'b1, 32'h5000_0000, 4'd3);
        addr_phase(1'b1, 32'h5000_0000, 4'd3, 0);
        axi_wready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1; wr_data = pat(32'h5000_0000, i); wr_strb = 8'hFF;
            @(negedge clock);
            check("rst_w_beat", wr_ready, 1);
            @(posedge clock); #1;
        end
        wr_data = pat(32'h5000_0000, 2);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_wvalid", axi_wvalid, 0);
        check("midrst_req_ready", req_ready, 1);
        check("midrst_done", done, 0);
        check("midrst_bready", axi_bready, 0);
        @(posedge clock); #1;
        reset = 1'b0; wr_valid = 1'b0; axi_wready = 1'b0;
        exp_err = 0;
        @(negedge clock);
        check("postrst_done", done, 0);
        check("postrst_req_ready", req_ready, 1);
        @(posedge clock); #1;

        send_cmd(1'b0, 32'h0000_0008, 4'd1);
        addr_phase(1'b0, 32'h0000_0008, 4'd1, 2);
        read_data(32'h0000_0008, 4'd1, 1, 2'd1, -1);

        // 32-bit build: size 2 and 4-bit strobes forwarded unchanged.
        req_valid_n = 1'b1; req_write_n = 1'b1; req_addr_n = 32'h0000_0106; req_len_n = 4'd1;
        @(negedge clock);
        check("n_req_ready", req_ready_n, 1);
        @(posedge clock); #1;
        req_valid_n = 1'b0; axi_awready_n = 1'b1;
        @(negedge clock);
        check("n_awvalid", axi_awvalid_n, 1);
        check("n_awaddr", axi_awaddr_n, 32'h0000_0104);
        check("n_awsize", axi_awsize_n, 2);
        check("n_awlen", axi_awlen_n, 1);
        @(posedge clock); #1;
        axi_awready_n = 1'b0; axi_wready_n = 1'b1; wr_valid_n = 1'b1;
        wr_data_n = 32'hCAFE_0001; wr_strb_n = 4'hA;
        @(negedge clock);
        check("n_wstrb0", axi_wstrb_n, 4'hA);
        check("n_wdata0", axi_wdata_n, 32'hCAFE_0001);
        check("n_wlast0", axi_wlast_n, 0);
        @(posedge clock); #1;
        wr_data_n = 32'hCAFE_0002; wr_strb_n = 4'h5;
        @(negedge clock);
        check("n_wstrb1", axi_wstrb_n, 4'h5);
        check("n_wlast1", axi_wlast_n, 1);
        @(posedge clock); #1;
        wr_valid_n = 1'b0; axi_wready_n = 1'b0; axi_bvalid_n = 1'b1;
        @(negedge clock);
        check("n_bready", axi_bready_n, 1);
        @(posedge clock); #1;
        axi_bvalid_n = 1'b0;
        @(negedge clock);
        check("n_done", done_n, 1);
        check("n_done_resp", done_resp_n, 0);
        @(posedge clock); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
